ext_unit_pipe: RTL and testbench
================================

Name: ext_unit_pipe

Overview:
- Parametrised, handshaked successor to the fixed 4-to-8 registered sign-extender.
- Takes an IN_W-bit immediate and produces an OUT_W-bit result in one of four extension modes.
- Uses a valid/ready interface with a 2-entry skid buffer, so it sustains full throughput and back-pressure is never combinational.
- Sits between instruction decode and the ALU operand mux.

Parameters:
- IN_W, 4, input field width; legal range 1..OUT_W.
- OUT_W, 8, output width; OUT_W >= IN_W.
- SHIFT, 1, left-shift amount for mode 2; legal range 0..OUT_W-IN_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- in_data  in  IN_W  immediate field.
- in_mode  in  2  extension mode, sampled with in_data.
- in_valid  in  1  in_data/in_mode valid.
- in_ready  out  1  block can accept; registered.
- out_data  out  OUT_W  extended result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- xfer_count  out  16  accepted-transaction count; present only with EXT_COUNT_EN.

Behaviour:
- Reset:
  - Clock is clk. Reset rst is asynchronous and active-low.
  - While rst=0: out_data=0, out_valid=0, in_ready=0, skid empty, xfer_count=0.
  - First edge after deassertion: in_ready=1.
- Modes, computed combinationally on the input side and registered:
  - 0 zero: {(OUT_W-IN_W) zeros, in_data}.
  - 1 sign: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
  - 2 sign-shift: sign-extend to OUT_W, then shift left by SHIFT with zero fill (branch offsets).
  - 3 upper: in_data in bits [OUT_W-1:OUT_W-IN_W], zeros below.
  - When OUT_W==IN_W, modes 0 and 1 are pass-through, and mode 3 equals pass-through.
- Handshake:
  - Input accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - in_data and in_mode are don't-care when in_valid=0.
  - out_data is held stable while out_valid=1 & out_ready=0.
- Latency: one cycle. An item accepted on edge N drives out_valid=1 after edge N when the output register is free or draining.
- State, encoded by occupancy of the output register (O) and skid register (S):
  - EMPTY: O=0, S=0.
    - Accept loads O.
  - ONE: O=1, S=0.
    - Accept with output transfer: new item into O.
    - Accept without output transfer: new item into S, go to FULL.
    - Output transfer without accept: go to EMPTY.
  - FULL: O=1, S=1, in_ready=0.
    - Output transfer: S moves to O, go to ONE.
- in_ready = !(next state FULL), registered.
- Simultaneous accept and transfer in ONE keeps ONE, giving 1 item/cycle throughput.
- Ordering is strict FIFO; no reordering or dropping.
- Reset asserted mid-operation discards O and S immediately (asynchronous); nothing is emitted afterwards.
- No invalid states: the S=1, O=0 encoding is unreachable. Implementation guards against it by treating it as EMPTY.

Optional Feature:
- Macro EXT_COUNT_EN.
- When defined:
  - Port xfer_count exists.
  - Increments by 1 on each output transfer (out_valid & out_ready).
  - Wraps 16'hFFFF -> 0. Reset to 0.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Defaults, mode 1, in_data=4'b1010, out_ready=1 -> next cycle out_data=8'hFA, out_valid=1. Mode 0 with the same data -> 8'h0A.
- Mode 2, in_data=4'b1001, SHIFT=1 -> 8'hF2. Mode 3, in_data=4'h5 -> 8'h50.
- Stream 4'h1..4'h8, mode 0, out_ready=1 -> eight outputs 8'h01..8'h08 on consecutive cycles; in_ready stays 1.
- out_ready=0 while sending 4'h3, 4'h4 -> after the 2nd accept in_ready=0, and out_data holds 8'h03. Raise out_ready -> 8'h03 then 8'h04 in order; in_ready returns to 1.
- In FULL, pulse rst low for half a cycle -> out_valid, in_ready and out_data go to 0 immediately. After release, no stale data appears and in_ready=1 after the first edge.
- With EXT_COUNT_EN, perform 65537 transfers -> xfer_count=1. Stall out_ready=0 for 10 cycles -> count unchanged.

Source files
------------

// File: rtl/ext_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ext_unit_pipe_if
// Description : Valid/ready bundle for the immediate extension pipe. Carries
//               the input-side immediate/mode handshake and the output-side
//               result handshake. The design uses the slave view; the
//               producer/consumer driving it uses the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ext_unit_pipe_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Producer of immediates and consumer of results
    modport master (
        output in_data,
        output in_mode,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    // The extension pipe itself
    modport slave (
        input  in_data,
        input  in_mode,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ext_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ext_unit_pipe
// Description : Handshaked immediate extender between decode and the ALU
//               operand mux. Extends an IN_W-bit field to OUT_W bits in one
//               of four modes (zero, sign, sign-shift, upper) with one cycle
//               of latency. A 2-entry skid (output reg + skid reg) keeps full
//               throughput while in_ready stays a pure register output.
//               Optional transfer counter enabled by macro EXT_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_unit_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,      // asynchronous, active-low
    ext_unit_pipe_if.slave  bus
`ifdef EXT_COUNT_EN
    ,
    output logic [15:0]     xfer_count
`endif
);

    // Occupancy encoding: bit0 = output register full, bit1 = skid full.
    // 2'b10 (skid without output) cannot be reached and decodes as EMPTY.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [OUT_W-1:0] o_data;
    logic [OUT_W-1:0] s_data;
    logic             in_ready_q;

    logic [OUT_W-1:0] ext_zero;
    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_shift;
    logic [OUT_W-1:0] ext_upper;
    logic [OUT_W-1:0] ext_result;

    logic             accept;
    logic             xfer;
    logic             out_valid_int;
    logic             load_o_in;
    logic             load_o_skid;
    logic             load_s;

    // Extension modes computed on the incoming field before registering
    always_comb begin
        ext_zero  = OUT_W'(bus.in_data);
        ext_sign  = OUT_W'($signed(bus.in_data));
        ext_shift = ext_sign << SHIFT;
        ext_upper = ext_zero << (OUT_W - IN_W);
        case (bus.in_mode)
            2'd0:    ext_result = ext_zero;
            2'd1:    ext_result = ext_sign;
            2'd2:    ext_result = ext_shift;
            default: ext_result = ext_upper;
        endcase
    end

    assign out_valid_int = (state == ONE) || (state == FULL);
    assign accept        = bus.in_valid & in_ready_q;
    assign xfer          = out_valid_int & bus.out_ready;

    // Next occupancy and which register gets loaded from where
    always_comb begin
        state_next  = state;
        load_o_in   = 1'b0;
        load_o_skid = 1'b0;
        load_s      = 1'b0;
        case (state)
            ONE: begin
                if (accept && xfer) begin
                    load_o_in  = 1'b1;
                end else if (accept) begin
                    load_s     = 1'b1;
                    state_next = FULL;
                end else if (xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain can happen
                if (xfer) begin
                    load_o_skid = 1'b1;
                    state_next  = ONE;
                end
            end
            default: begin
                // EMPTY and the unreachable skid-only code
                if (accept) begin
                    load_o_in  = 1'b1;
                    state_next = ONE;
                end else begin
                    state_next = EMPTY;
                end
            end
        endcase
    end

    // Occupancy state and registered ready (low exactly when heading to FULL)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    // Output and skid data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_data <= '0;
            s_data <= '0;
        end else begin
            if (load_o_in) begin
                o_data <= ext_result;
            end else if (load_o_skid) begin
                o_data <= s_data;
            end
            if (load_s) begin
                s_data <= ext_result;
            end
        end
    end

    assign bus.out_data  = o_data;
    assign bus.out_valid = out_valid_int;
    assign bus.in_ready  = in_ready_q;

`ifdef EXT_COUNT_EN
    // Count completed output transfers, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_count <= 16'd0;
        end else if (xfer) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_unit_pipe
// Description : Directed self-checking bench for ext_unit_pipe with default
//               parameters (IN_W=4, OUT_W=8, SHIFT=1). Counter checks are
//               included when EXT_COUNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_unit_pipe;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ext_unit_pipe_if #(.IN_W(4), .OUT_W(8)) bus ();

`ifdef EXT_COUNT_EN
    logic [15:0] xfer_count;
`endif

    ext_unit_pipe #(
        .IN_W  (4),
        .OUT_W (8),
        .SHIFT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef EXT_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h00);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Individual modes, consumer always ready
        bus.out_ready = 1'b1;
        send(4'b1010, 2'd1);
        step();
        check("mode1_valid", 32'(bus.out_valid), 32'd1);
        check("mode1_data",  32'(bus.out_data),  32'hFA);
        send(4'b1010, 2'd0);
        step();
        check("mode0_data",  32'(bus.out_data),  32'h0A);
        send(4'b1001, 2'd2);
        step();
        check("mode2_data",  32'(bus.out_data),  32'hF2);
        send(4'h5, 2'd3);
        step();
        check("mode3_data",  32'(bus.out_data),  32'h50);
        send(4'h6, 2'd2);
        step();
        check("mode2_pos_data", 32'(bus.out_data), 32'h0C);
        bus.in_valid = 1'b0;
        step();
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // Full-throughput stream
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), 2'd0);
            step();
            check("stream_data",     32'(bus.out_data),  32'(i));
            check("stream_valid",    32'(bus.out_valid), 32'd1);
            check("stream_in_ready", 32'(bus.in_ready),  32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_end_valid", 32'(bus.out_valid), 32'd0);

        // Back-pressure fills the skid
        bus.out_ready = 1'b0;
        send(4'h3, 2'd0);
        step();
        check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp1_data",     32'(bus.out_data), 32'h03);
        send(4'h4, 2'd0);
        step();
        check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp2_data",     32'(bus.out_data), 32'h03);
        send(4'hE, 2'd1);  // must be ignored while full
        step();
        check("bp_hold_data",  32'(bus.out_data),  32'h03);
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_drain1_data",     32'(bus.out_data), 32'h04);
        check("bp_drain1_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_drain2_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        send(4'h7, 2'd0);
        step();
        send(4'h9, 2'd0);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_full_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("async_rst_out_data",  32'(bus.out_data),  32'h00);
        #4 rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("rel_no_stale", 32'(bus.out_valid), 32'd0);

`ifdef EXT_COUNT_EN
        check("cnt_after_rst", 32'(xfer_count), 32'd0);
        // 65537 transfers: accept on every edge, last item drains one edge later
        send(4'h1, 2'd0);
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("cnt_wrap", 32'(xfer_count), 32'd1);
        bus.out_ready = 1'b0;
        send(4'h2, 2'd0);
        for (int i = 0; i < 10; i++) begin
            step();
        end
        check("cnt_stall", 32'(xfer_count), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        check("cnt_after_stall", 32'(xfer_count), 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global safety bound
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
